led_blink_decoder: RTL and testbench

Receive-side counterpart to the LED blink generator: samples a blinking square wave (e.g. the LED drive line looped back or a photodiode comparator output), measures each half-period in clock cycles, and classifies it into one of the four blink-rate codes the generator's switch pair selects. It sits at the board input, feeding self-test logic and status display; it reports the decoded 2-bit rate code, a lock flag, and a loss-of-signal flag.

---
 rtl/led_blink_decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_led_blink_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_decoder.sv
// led_blink_decoder: measures half-periods of a looped-back blink waveform and classifies them
// into four rate codes with lock / loss-of-signal reporting. Optional filter: LED_BLINK_DECODER_GLITCH_FILTER_EN.
module led_blink_decoder #(
    parameter int CLK_HZ      = 25_000_000,
    parameter int F0_HZ       = 100,
    parameter int F1_HZ       = 50,
    parameter int F2_HZ       = 10,
    parameter int F3_HZ       = 1,
    parameter int LOCK_COUNT  = 4,
    parameter int FILT_CYCLES = 8,
    parameter int COUNT_W     = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               blink_in,
    output logic [1:0]         rate_code,
    output logic               rate_valid,
    output logic               no_signal,
    output logic               meas_strobe,
    output logic [COUNT_W-1:0] half_period
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SYNC   = 2'b01,
        ST_MEAS   = 2'b10,
        ST_LOCKED = 2'b11
    } state_t;

    localparam logic [COUNT_W-1:0] H0      = COUNT_W'(CLK_HZ / (2 * F0_HZ));
    localparam logic [COUNT_W-1:0] H1      = COUNT_W'(CLK_HZ / (2 * F1_HZ));
    localparam logic [COUNT_W-1:0] H2      = COUNT_W'(CLK_HZ / (2 * F2_HZ));
    localparam logic [COUNT_W-1:0] H3      = COUNT_W'(CLK_HZ / (2 * F3_HZ));
    localparam logic [COUNT_W-1:0] TMO     = COUNT_W'(2 * (CLK_HZ / (2 * F3_HZ)));
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]         LOCK_N  = 4'(LOCK_COUNT);

    if (LOCK_COUNT < 1 || LOCK_COUNT > 15 || FILT_CYCLES < 1) begin : g_param_check
        $error("led_blink_decoder: LOCK_COUNT must be 1..15 and FILT_CYCLES at least 1");
    end

    // True when hp lies within nominal +/- one eighth, inclusive.
    function automatic logic in_window(input logic [COUNT_W-1:0] hp, input logic [COUNT_W-1:0] nom);
        in_window = (hp >= (nom - (nom >> 3'd3))) && (hp <= (nom + (nom >> 3'd3)));
    endfunction

    logic               sync1_r;
    logic               sync2_r;
    logic               filt_level_s;
    logic               prev_r;
    logic               edge_r;
    logic [COUNT_W-1:0] cnt_r;
    logic               tmo_s;
    logic               cls_hit_s;
    logic [1:0]         cls_code_s;
    state_t             state_r;
    state_t             state_s;
    logic [3:0]         match_cnt_r;
    logic [3:0]         match_cnt_s;
    logic [1:0]         match_cls_r;
    logic [1:0]         match_cls_s;
    logic               strobe_s;
    logic [COUNT_W-1:0] half_period_s;
    logic [1:0]         rate_code_s;
    logic               rate_valid_s;
    logic               no_signal_s;

    // Two-flop synchronizer for the asynchronous blink input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= blink_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef LED_BLINK_DECODER_GLITCH_FILTER_EN
    localparam int FILT_W = $clog2(FILT_CYCLES + 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYCLES - 1);

    logic              filt_r;
    logic [FILT_W-1:0] filt_cnt_r;

    // Glitch filter: adopt a new level only after it has been stable for FILT_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_r     <= 1'b0;
            filt_cnt_r <= {FILT_W{1'b0}};
        end else if (sync2_r == filt_r) begin
            filt_cnt_r <= {FILT_W{1'b0}};
        end else if (filt_cnt_r == FILT_LAST) begin
            filt_r     <= sync2_r;
            filt_cnt_r <= {FILT_W{1'b0}};
        end else begin
            filt_cnt_r <= filt_cnt_r + 1'b1;
        end
    end

    assign filt_level_s = filt_r;
`else
    assign filt_level_s = sync2_r;
`endif

    // Registered both-edge detector on the filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
            edge_r <= 1'b0;
        end else begin
            prev_r <= filt_level_s;
            edge_r <= filt_level_s ^ prev_r;
        end
    end

    // Half-period counter: restarts at 1 on every edge so its value at the next edge is the interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {COUNT_W{1'b0}};
        end else if (edge_r) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tmo_s = (cnt_r >= TMO);

    // Map the interval just completed onto a rate class; windows are disjoint.
    always_comb begin
        cls_hit_s  = 1'b1;
        cls_code_s = 2'b00;
        if (in_window(cnt_r, H0)) begin
            cls_code_s = 2'b00;
        end else if (in_window(cnt_r, H1)) begin
            cls_code_s = 2'b01;
        end else if (in_window(cnt_r, H2)) begin
            cls_code_s = 2'b10;
        end else if (in_window(cnt_r, H3)) begin
            cls_code_s = 2'b11;
        end else begin
            cls_hit_s  = 1'b0;
            cls_code_s = 2'b00;
        end
    end

    // Next-state, match tracking and next output values.
    always_comb begin
        state_s       = state_r;
        match_cnt_s   = match_cnt_r;
        match_cls_s   = match_cls_r;
        strobe_s      = 1'b0;
        half_period_s = half_period;
        case (state_r)
            ST_IDLE: begin
                if (edge_r) begin
                    state_s     = ST_SYNC;
                    match_cnt_s = 4'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (edge_r) begin
                    state_s       = ST_MEAS;
                    strobe_s      = 1'b1;
                    half_period_s = cnt_r;
                end else if (tmo_s) begin
                    state_s     = ST_IDLE;
                    match_cnt_s = 4'd0;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_MEAS, ST_LOCKED: begin
                if (edge_r) begin
                    strobe_s      = 1'b1;
                    half_period_s = cnt_r;
                    if (!cls_hit_s) begin
                        match_cnt_s = 4'd0;
                    end else if ((match_cnt_r != 4'd0) && (cls_code_s == match_cls_r)) begin
                        if (match_cnt_r < LOCK_N) begin
                            match_cnt_s = match_cnt_r + 4'd1;
                        end else begin
                            match_cnt_s = match_cnt_r;
                        end
                    end else begin
                        match_cnt_s = 4'd1;
                        match_cls_s = cls_code_s;
                    end
                    if (match_cnt_s >= LOCK_N) begin
                        state_s = ST_LOCKED;
                    end else begin
                        state_s = ST_MEAS;
                    end
                end else if (tmo_s) begin
                    state_s     = ST_IDLE;
                    match_cnt_s = 4'd0;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                match_cnt_s = 4'd0;
            end
        endcase
        no_signal_s  = (state_s == ST_IDLE);
        rate_valid_s = (state_s == ST_LOCKED);
        if (rate_valid_s) begin
            rate_code_s = match_cls_s;
        end else begin
            rate_code_s = rate_code;
        end
    end

    // State, match tracking and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            match_cnt_r <= 4'd0;
            match_cls_r <= 2'b00;
            rate_code   <= 2'b00;
            rate_valid  <= 1'b0;
            no_signal   <= 1'b1;
            meas_strobe <= 1'b0;
            half_period <= {COUNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            match_cnt_r <= match_cnt_s;
            match_cls_r <= match_cls_s;
            rate_code   <= rate_code_s;
            rate_valid  <= rate_valid_s;
            no_signal   <= no_signal_s;
            meas_strobe <= strobe_s;
            half_period <= half_period_s;
        end
    end

endmodule

// File: tb/tb_led_blink_decoder.sv
// Self-checking bench for led_blink_decoder: directed phases plus randomized intervals,
// compared against an interval-level reference model of the decoding rules.
module tb_led_blink_decoder;

    localparam int CLK_HZ      = 2000;
    localparam int LOCK_COUNT  = 4;
    localparam int FILT_CYCLES = 8;
    localparam int COUNT_W     = 26;
    localparam int TMO         = 2 * (CLK_HZ / 2);
`ifdef LED_BLINK_DECODER_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif

    logic               clk;
    logic               rst_n;
    logic               blink_in;
    logic [1:0]         rate_code;
    logic               rate_valid;
    logic               no_signal;
    logic               meas_strobe;
    logic [COUNT_W-1:0] half_period;

    led_blink_decoder #(
        .CLK_HZ(CLK_HZ), .F0_HZ(100), .F1_HZ(50), .F2_HZ(10), .F3_HZ(1),
        .LOCK_COUNT(LOCK_COUNT), .FILT_CYCLES(FILT_CYCLES), .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .blink_in(blink_in),
        .rate_code(rate_code), .rate_valid(rate_valid), .no_signal(no_signal),
        .meas_strobe(meas_strobe), .half_period(half_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observed strobes
    int cyc = 0;
    int last_strobe_cyc = 0;
    int q_hp[$];
    bit q_rv[$];
    int q_rc[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (meas_strobe === 1'b1) begin
            q_hp.push_back(int'(half_period));
            q_rv.push_back(rate_valid === 1'b1);
            q_rc.push_back(int'(rate_code));
            last_strobe_cyc <= cyc + 1;
        end
    end

    // Reference model state: input toggle times and expected strobes
    longint tog_t[$];
    longint last_edge = 0;
    int     acq = 0;
    int     hist[$];
    int     e_hp[$];
    bit     e_rv[$];
    int     e_rc[$];

    function automatic int nominal(input int k);
        case (k)
            0:       return CLK_HZ / (2 * 100);
            1:       return CLK_HZ / (2 * 50);
            2:       return CLK_HZ / (2 * 10);
            default: return CLK_HZ / (2 * 1);
        endcase
    endfunction

    function automatic int cls_of(input longint n);
        for (int k = 0; k < 4; k++) begin
            int h;
            h = nominal(k);
            if (n >= h - (h >> 3) && n <= h + (h >> 3)) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input longint t);
        longint n;
        int c;
        bit ok;
        n = t - last_edge;
        if (acq == 0 || n > TMO) begin
            acq = 1;
            hist.delete();
        end else if (acq == 1) begin
            acq = 2;
            e_hp.push_back(int'(n));
            e_rv.push_back(1'b0);
            e_rc.push_back(0);
        end else begin
            hist.push_back(cls_of(n));
            c  = hist[hist.size()-1];
            ok = (c >= 0) && (hist.size() >= LOCK_COUNT);
            if (ok) begin
                for (int j = 1; j < LOCK_COUNT; j++)
                    if (hist[hist.size()-1-j] != c) ok = 1'b0;
            end
            e_hp.push_back(int'(n));
            e_rv.push_back(ok);
            e_rc.push_back(ok ? c : 0);
        end
        last_edge = t;
    endtask

    // Turn recorded toggles into filtered edges (short pulses vanish when filtering) and feed the model.
    task automatic drain_model();
        int i;
        i = 0;
        while (i < tog_t.size()) begin
            if (FILT_ON && (i + 1 < tog_t.size()) && (tog_t[i+1] - tog_t[i] < FILT_CYCLES)) begin
                i += 2;
            end else begin
                model_edge(tog_t[i]);
                i++;
            end
        end
        tog_t.delete();
    endtask

    task automatic check_strobes(input string tag);
        int n;
        #1;
        drain_model();
        chk({tag, " strobe count"}, q_hp.size(), e_hp.size());
        n = (q_hp.size() < e_hp.size()) ? q_hp.size() : e_hp.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s half_period[%0d]", tag, i), q_hp[i], e_hp[i]);
            chk($sformatf("%s rate_valid[%0d]", tag, i), q_rv[i], e_rv[i]);
            if (e_rv[i]) chk($sformatf("%s rate_code[%0d]", tag, i), q_rc[i], e_rc[i]);
        end
        q_hp.delete(); q_rv.delete(); q_rc.delete();
        e_hp.delete(); e_rv.delete(); e_rc.delete();
    endtask

    task automatic seg(input logic lvl, input int dur);
        if (lvl !== blink_in) begin
            blink_in = lvl;
            tog_t.push_back($time / 10);
        end
        repeat (dur) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rate_code"}, rate_code, 2'b00);
        chk({tag, " rate_valid"}, rate_valid, 1'b0);
        chk({tag, " no_signal"}, no_signal, 1'b1);
        chk({tag, " meas_strobe"}, meas_strobe, 1'b0);
        chk({tag, " half_period"}, half_period, 0);
    endtask

    initial begin
        bit found;
        int k;
        int d;
        int h;
        int p;
        int first_rv;
        rst_n    = 1'b0;
        blink_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Static input: never acquires
        seg(1'b0, 3000);
        chk("static no_signal", no_signal, 1'b1);
        chk("static rate_valid", rate_valid, 1'b0);
        check_strobes("static");

        // 20-cycle toggling locks to code 01
        for (int i = 0; i < 10; i++) seg(~blink_in, 20);
        chk("lock01 rate_valid", rate_valid, 1'b1);
        chk("lock01 rate_code", rate_code, 2'b01);

        // Switch to 100-cycle toggling, relock to code 10
        for (int i = 0; i < 8; i++) seg(~blink_in, 100);
        chk("lock10 rate_valid", rate_valid, 1'b1);
        chk("lock10 rate_code", rate_code, 2'b10);
        check_strobes("rate switch");

        // 15-cycle toggling is outside every window, then the signal stops
        for (int i = 0; i < 8; i++) seg(~blink_in, 15);
        chk("oow rate_valid", rate_valid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 3 * TMO && !found; i++) begin
            @(negedge clk);
            #1;
            if (no_signal === 1'b1) found = 1'b1;
        end
        chk("no_signal rises", found, 1'b1);
        if (found) chk("no_signal delay", cyc - last_strobe_cyc, TMO);
        check_strobes("out of window");

        // Randomized runs of in-window jitter with occasional stray intervals
        for (int g = 0; g < 6; g++) begin
            k = int'($urandom_range(0, 2));
            h = nominal(k);
            for (int j = 0; j < 6; j++) begin
                d = h - (h >> 3) + int'($urandom_range(0, 2 * (h >> 3)));
                if ($urandom_range(0, 9) == 0) d = int'($urandom_range(12, 150));
                seg(~blink_in, d);
            end
        end
        seg(blink_in, 30);
        check_strobes("random");

        // Lock at code 00, then asynchronous reset mid-interval
        for (int i = 0; i < 12; i++) seg(~blink_in, 10);
        seg(blink_in, 5);
        chk("lock00 rate_valid", rate_valid, 1'b1);
        chk("lock00 rate_code", rate_code, 2'b00);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        blink_in = 1'b0;
        tog_t.delete();
        q_hp.delete(); q_rv.delete(); q_rc.delete();
        acq = 0;
        hist.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) seg(~blink_in, 10);
        seg(blink_in, 30);
        #1;
        first_rv = -1;
        for (int i = 0; i < q_rv.size(); i++)
            if (q_rv[i] && first_rv < 0) first_rv = i;
        chk("relock strobe index", first_rv, LOCK_COUNT);
        check_strobes("after reset");

        // Steady 1000-cycle toggling with short glitches inside some half-periods
        for (int i = 0; i < 7; i++) seg(~blink_in, 1000);
        for (int g = 0; g < 3; g++) begin
            p = int'($urandom_range(200, 600));
            seg(~blink_in, p);
            seg(~blink_in, 3);
            seg(~blink_in, 1000 - p - 3);
            seg(~blink_in, 1000);
        end
        seg(blink_in, 50);
        chk("glitch rate_valid", rate_valid, FILT_ON ? 1'b1 : 1'b0);
        if (FILT_ON) chk("glitch rate_code", rate_code, 2'b11);
        check_strobes("glitch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
